conv_weight_loader: RTL and testbench
=====================================

Name: conv_weight_loader

Overview:
Sequencer that streams 3x3 kernel weights plus bias from a weight memory into the conv_weights shift register, then triggers and waits for one convolution pass per kernel. It sits between the weight ROM/RAM and the conv_weights + conv engine pair, and can load a single kernel or iterate over all kernels of a layer. It guarantees the contiguous wr_en burst that conv_weights requires.

Parameters:
DATA_W, 16, weight/bias word width
WORDS_PER_KERNEL, 10, words per kernel (9 weights + bias), written in order w11..w33, bias
N_KERNELS, 4, kernels stored in memory
KIDX_W, 2, width of kernel index (clog2(N_KERNELS), min 1)
ADDR_W, 6, memory address width (must hold N_KERNELS*WORDS_PER_KERNEL-1)
RDY_TIMEOUT, 15, max cycles to wait for weights_ready after the burst

Ports:
pclk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of pclk
start  in  1  one-cycle request, sampled only in IDLE
auto_all  in  1  sampled with start: 1 = run kernels 0..N_KERNELS-1, 0 = run kernel_idx only
kernel_idx  in  KIDX_W  kernel selected when auto_all=0, sampled with start
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
wr_en  out  1  to conv_weights wr_en
wr_data  out  DATA_W  to conv_weights wr_data
weights_ready  in  1  from conv_weights
conv_start  out  1  one-cycle pulse to conv engine
conv_done  in  1  one-cycle pulse from conv engine
busy  out  1  high in every state except IDLE
cur_kernel  out  KIDX_W  kernel currently being loaded/run
done  out  1  one-cycle pulse: whole request finished OK
err  out  1  one-cycle pulse: bad index or ready timeout

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; mem_rd_en, wr_en, conv_start, busy, done, err = 0; mem_addr, wr_data, cur_kernel, counters = 0. Applies mid-operation too: burst aborted; wr_en drops the next cycle.
- States: IDLE, FETCH, WAIT_RDY, CONV, NEXT.
- IDLE: on start: if auto_all=0 and kernel_idx >= N_KERNELS -> err pulse next cycle, stay IDLE. Else cur_kernel <= (auto_all ? 0 : kernel_idx), go FETCH. start while busy is ignored (no queueing).
- FETCH: mem_rd_en=1 for exactly WORDS_PER_KERNEL consecutive cycles; mem_addr = cur_kernel*WORDS_PER_KERNEL + word_cnt (word_cnt 0..9). wr_en/wr_data = mem_rd_en/mem_rd_data delayed one cycle (registered), giving one unbroken 10-cycle wr_en burst with no gaps. Leave FETCH when the last wr_en cycle is issued.
- WAIT_RDY: entered the cycle after the last wr_en. Timer starts at 0. weights_ready=1 -> CONV, asserting conv_start for that one cycle. Timer reaching RDY_TIMEOUT without ready -> err pulse, IDLE.
- CONV: wait for conv_done; no timeout. conv_done in the same cycle conv_start is issued is ignored.
- NEXT (one cycle): if auto_all latched and cur_kernel < N_KERNELS-1 -> cur_kernel+1, FETCH. Else done pulse, IDLE.
- Arithmetic: base address is a width-safe product. Truncation to ADDR_W is never needed when the parameter rules hold.
- done and err are mutually exclusive and never both asserted in the same cycle.
- Load latency: wr_en starts 2 cycles after start is sampled; last wr_en is 11 cycles after start.

Decomposition:
- Package conv_pkg: DATA_W, WORDS_PER_KERNEL, state enum encoding, RDY_TIMEOUT default; shared with conv_weights and the conv engine.
- One natural sub-module: wl_burst_gen. It holds the word counter, address generation, and the 1-cycle rd_en -> wr_en alignment. It is started by the FSM and returns burst_last.

Test Plan:
- Reset, then start, auto_all=0, kernel_idx=2, memory word[a]=a -> mem_addr 20..29. wr_en high 10 contiguous cycles with wr_data 20..29. After ready, conv_start pulse once. conv_done -> done pulse. conv_weights shows w11=20, bias=29.
- auto_all=1, N_KERNELS=4 -> four bursts (addresses 0..9, 10..19, 20..29, 30..39), four conv_start pulses, cur_kernel 0..3, a single done after the 4th conv_done.
- kernel_idx=3 with N_KERNELS=3 -> err one cycle after start; no mem_rd_en, no wr_en; busy stays 0.
- weights_ready held 0 by bench -> err exactly RDY_TIMEOUT=15 cycles after entering WAIT_RDY; state returns to IDLE; no conv_start.
- rst_n low during the 5th wr_en cycle -> next cycle wr_en=0, busy=0, all outputs at reset values. A new start then yields a full clean 10-word burst.
- start pulsed again during CONV -> ignored; exactly one done for the original request.

Source files
------------

// File: rtl/conv_weight_loader_pkg.sv
// Shared widths, defaults and FSM encoding for the conv weight loader and its neighbours.
package conv_weight_loader_pkg;
  localparam int CWL_DATA_W           = 16;
  localparam int CWL_WORDS_PER_KERNEL = 10;
  localparam int CWL_RDY_TIMEOUT      = 15;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_CONV     = 3'd3,
    S_NEXT     = 3'd4
  } cwl_state_t;
endpackage

// File: rtl/conv_weight_loader_if.sv
// Control, weight-memory, conv_weights and conv-engine signals of the loader.
interface conv_weight_loader_if #(
  parameter int DATA_W = 16,
  parameter int KIDX_W = 2,
  parameter int ADDR_W = 6
);
  logic              start;
  logic              auto_all;
  logic [KIDX_W-1:0] kernel_idx;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              weights_ready;
  logic              conv_start;
  logic              conv_done;
  logic              busy;
  logic [KIDX_W-1:0] cur_kernel;
  logic              done;
  logic              err;

  modport master (
    input  start, auto_all, kernel_idx, mem_rd_data, weights_ready, conv_done,
    output mem_rd_en, mem_addr, wr_en, wr_data, conv_start, busy, cur_kernel, done, err
  );

  modport slave (
    output start, auto_all, kernel_idx, mem_rd_data, weights_ready, conv_done,
    input  mem_rd_en, mem_addr, wr_en, wr_data, conv_start, busy, cur_kernel, done, err
  );
endinterface

// File: rtl/conv_weight_loader_burst_gen.sv
// Issues one kernel's worth of memory reads and replays the returned data as an
// unbroken wr_en burst, one cycle behind the read data.
module conv_weight_loader_burst_gen #(
  parameter int DATA_W           = 16,
  parameter int ADDR_W           = 6,
  parameter int KIDX_W           = 2,
  parameter int WORDS_PER_KERNEL = 10
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              i_go,
  input  logic [KIDX_W-1:0] i_kidx,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_last
);
  localparam int CNT_W = (WORDS_PER_KERNEL > 1) ? $clog2(WORDS_PER_KERNEL) : 1;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_d1;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] w_base;

  assign w_base = ADDR_W'(i_kidx) * ADDR_W'(WORDS_PER_KERNEL);

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_rd_d1   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      // read data lands one cycle after rd_en; register it once more for wr_data
      r_rd_d1 <= r_rd_en;
      r_wr_en <= r_rd_d1;
      if (r_rd_d1) r_wr_data <= i_rd_data;
      if (i_go) begin
        r_rd_en <= 1'b1;
        r_cnt   <= '0;
        r_addr  <= w_base;
      end else if (r_rd_en) begin
        if (r_cnt == CNT_W'(WORDS_PER_KERNEL - 1)) begin
          r_rd_en <= 1'b0;
        end else begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_addr <= r_addr + ADDR_W'(1);
        end
      end
    end
  end

  assign o_rd_en   = r_rd_en;
  assign o_addr    = r_addr;
  assign o_wr_en   = r_wr_en;
  assign o_wr_data = r_wr_data;
  // final write of the burst: nothing left in the read pipeline behind it
  assign o_last    = r_wr_en & ~r_rd_d1 & ~r_rd_en;
endmodule

// File: rtl/conv_weight_loader.sv
// Loads 3x3 kernels plus bias into conv_weights and runs one conv pass per kernel,
// either for a single selected kernel or for every kernel of the layer.
module conv_weight_loader
  import conv_weight_loader_pkg::*;
#(
  parameter int DATA_W           = CWL_DATA_W,
  parameter int WORDS_PER_KERNEL = CWL_WORDS_PER_KERNEL,
  parameter int N_KERNELS        = 4,
  parameter int KIDX_W           = 2,
  parameter int ADDR_W           = 6,
  parameter int RDY_TIMEOUT      = CWL_RDY_TIMEOUT
) (
  input logic                pclk,
  input logic                rst_n,
  conv_weight_loader_if.master bus
);
  localparam int TMR_W = $clog2(RDY_TIMEOUT + 1);

  cwl_state_t        r_state;
  logic              r_auto;
  logic [KIDX_W-1:0] r_cur;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_conv_start;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_idx_ok;
  logic              w_more;
  logic              w_go;
  logic [KIDX_W-1:0] w_go_kidx;
  logic              w_last;

  assign w_idx_ok  = int'(bus.kernel_idx) < N_KERNELS;
  assign w_more    = r_auto && (int'(r_cur) < N_KERNELS - 1);
  assign w_go      = ((r_state == S_IDLE) && bus.start && (bus.auto_all || w_idx_ok)) ||
                     ((r_state == S_NEXT) && w_more);
  assign w_go_kidx = (r_state == S_IDLE) ? (bus.auto_all ? '0 : bus.kernel_idx)
                                         : r_cur + KIDX_W'(1);

  conv_weight_loader_burst_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .KIDX_W(KIDX_W), .WORDS_PER_KERNEL(WORDS_PER_KERNEL)
  ) u_burst (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .i_go      (w_go),
    .i_kidx    (w_go_kidx),
    .o_rd_en   (bus.mem_rd_en),
    .o_addr    (bus.mem_addr),
    .i_rd_data (bus.mem_rd_data),
    .o_wr_en   (bus.wr_en),
    .o_wr_data (bus.wr_data),
    .o_last    (w_last)
  );

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_auto       <= 1'b0;
      r_cur        <= '0;
      r_tmr        <= '0;
      r_conv_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_conv_start <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (!bus.auto_all && !w_idx_ok) begin
              r_err <= 1'b1;
            end else begin
              r_auto  <= bus.auto_all;
              r_cur   <= w_go_kidx;
              r_busy  <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (w_last) begin
            r_tmr   <= '0;
            r_state <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (bus.weights_ready) begin
            r_conv_start <= 1'b1;
            r_state      <= S_CONV;
          end else if (r_tmr == TMR_W'(RDY_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        // a done coincident with our own start pulse belongs to an earlier pass
        S_CONV: begin
          if (bus.conv_done && !r_conv_start) r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (w_more) begin
            r_cur   <= w_go_kidx;
            r_state <= S_FETCH;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.conv_start = r_conv_start;
  assign bus.busy       = r_busy;
  assign bus.cur_kernel = r_cur;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_conv_weight_loader.sv
// Scoreboard bench: expected reads, writes, burst lengths and kernel ids are queued at
// stimulus time and consumed as the loader produces them.
module tb_conv_weight_loader;
  import conv_weight_loader_pkg::*;
  localparam int DW = 16, KW = 2, AW = 6;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  conv_weight_loader_if #(.DATA_W(DW), .KIDX_W(KW), .ADDR_W(AW)) bus ();
  conv_weight_loader_if #(.DATA_W(DW), .KIDX_W(KW), .ADDR_W(AW)) bus3 ();

  conv_weight_loader #(.N_KERNELS(4), .KIDX_W(KW), .ADDR_W(AW)) u_dut (
    .pclk(pclk), .rst_n(rst_n), .bus(bus));
  conv_weight_loader #(.N_KERNELS(3), .KIDX_W(KW), .ADDR_W(AW)) u_dut3 (
    .pclk(pclk), .rst_n(rst_n), .bus(bus3));

  int n_chk = 0, n_fail = 0;
  int aq[$], wq[$], lq[$], kq[$];
  int run = 0, done_cnt = 0, err_cnt = 0, cs_cnt = 0;
  int rd3 = 0, wr3 = 0, busy3 = 0;
  int wcnt = 0, cdly = 0, conv_lat = 3;
  logic rdy_en = 1'b1;
  logic [DW-1:0] sr [10];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic pulse_start(input logic a, input logic [KW-1:0] k);
    bus.auto_all = a; bus.kernel_idx = k; bus.start = 1'b1;
    @(posedge pclk); #1;
    bus.start = 1'b0;
  endtask

  task automatic push_kernel(input int k, input int len);
    for (int i = 0; i < 10; i++) begin aq.push_back(k*10 + i); wq.push_back(k*10 + i); end
    lq.push_back(len);
  endtask

  task automatic clr_cnt();
    done_cnt = 0; err_cnt = 0; cs_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin step(1); n++; end
    chk("done_seen", bus.done, 1);
  endtask

  // weight memory: word[a] = a, one cycle read latency
  always @(posedge pclk) if (bus.mem_rd_en) bus.mem_rd_data <= DW'(bus.mem_addr);

  // conv_weights model: shift register, ready after ten writes
  always @(posedge pclk) begin
    if (!rst_n || bus.conv_start) wcnt <= 0;
    else if (bus.wr_en) wcnt <= (wcnt >= 10) ? 1 : wcnt + 1;
    if (bus.wr_en) begin
      for (int i = 9; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= bus.wr_data;
    end
  end
  assign bus.weights_ready = rdy_en && (wcnt >= 10);

  // conv engine model: done pulse conv_lat-1 cycles after start is seen
  always @(posedge pclk) begin
    if (!rst_n) cdly <= 0;
    else if (bus.conv_start) cdly <= conv_lat;
    else if (cdly > 0) cdly <= cdly - 1;
  end
  assign bus.conv_done = (cdly == 1);

  initial begin
    forever begin
      @(negedge pclk);
      if (bus.mem_rd_en) begin
        if (aq.size() == 0) chk("rd_unexp", 1, 0);
        else chk("rd_addr", 32'(bus.mem_addr), aq.pop_front());
      end
      if (bus.wr_en) begin
        run++;
        if (wq.size() == 0) chk("wr_unexp", 1, 0);
        else chk("wr_data", 32'(bus.wr_data), wq.pop_front());
      end else if (run > 0) begin
        if (lq.size() == 0) chk("burst_unexp", run, 0);
        else chk("burst_len", run, lq.pop_front());
        run = 0;
      end
      if (bus.conv_start) begin
        cs_cnt++;
        if (kq.size() == 0) chk("cs_unexp", 1, 0);
        else chk("cur_kernel", 32'(bus.cur_kernel), kq.pop_front());
      end
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
      if (bus.done && bus.err) chk("done_err_excl", 1, 0);
      if (bus3.mem_rd_en) rd3++;
      if (bus3.wr_en) wr3++;
      if (bus3.busy) busy3++;
    end
  end

  initial begin
    int n;
    bus.start = 0; bus.auto_all = 0; bus.kernel_idx = '0;
    bus3.start = 0; bus3.auto_all = 0; bus3.kernel_idx = '0;
    bus3.mem_rd_data = '0; bus3.weights_ready = 0; bus3.conv_done = 0;

    // reset state
    rst_n = 0; step(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.wr_data), 0);
    chk("rst_cur", 32'(bus.cur_kernel), 0);
    chk("rst_flags", {bus.conv_start, bus.done, bus.err}, 0);
    rst_n = 1; step(1);

    // single kernel 2
    push_kernel(2, 10); kq.push_back(2); clr_cnt();
    pulse_start(0, 2);
    chk("a_busy", bus.busy, 1);
    chk("a_cur", 32'(bus.cur_kernel), 2);
    chk("a_addr0", 32'(bus.mem_addr), 20);
    n = 0;
    while (!bus.wr_en && n < 50) begin step(1); n++; end
    chk("a_wr_lat", n, 2);
    wait_done(100); step(2);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_cs_cnt", cs_cnt, 1);
    chk("a_err_cnt", err_cnt, 0);
    chk("a_w11", 32'(sr[9]), 20);
    chk("a_bias", 32'(sr[0]), 29);
    chk("a_busy_end", bus.busy, 0);

    // all kernels
    for (int k = 0; k < 4; k++) begin push_kernel(k, 10); kq.push_back(k); end
    clr_cnt();
    pulse_start(1, 0);
    wait_done(400); step(5);
    chk("b_done_cnt", done_cnt, 1);
    chk("b_cs_cnt", cs_cnt, 4);
    chk("b_err_cnt", err_cnt, 0);
    chk("b_w11", 32'(sr[9]), 30);
    chk("b_bias", 32'(sr[0]), 39);

    // bad index on the three-kernel instance
    bus3.kernel_idx = 2'd3; bus3.start = 1;
    @(posedge pclk); #1;
    bus3.start = 0;
    chk("c_err", bus3.err, 1);
    chk("c_busy", bus3.busy, 0);
    step(1);
    chk("c_err_pulse", bus3.err, 0);
    step(5);
    chk("c_rd3", rd3, 0);
    chk("c_wr3", wr3, 0);
    chk("c_busy3", busy3, 0);

    // ready timeout
    rdy_en = 0; push_kernel(1, 10); clr_cnt();
    pulse_start(0, 1);
    n = 0;
    while (!bus.wr_en && n < 20) begin step(1); n++; end
    n = 0;
    while (bus.wr_en && n < 20) begin step(1); n++; end
    n = 0;
    while (!bus.err && n < 100) begin step(1); n++; end
    chk("d_tmo_lat", n, 15);
    chk("d_busy", bus.busy, 0);
    step(3);
    chk("d_cs_cnt", cs_cnt, 0);
    chk("d_err_cnt", err_cnt, 1);
    rdy_en = 1;

    // reset during the fifth write
    push_kernel(0, 5); clr_cnt();
    pulse_start(0, 0);
    n = 0;
    while (!bus.wr_en && n < 20) begin step(1); n++; end
    step(4);
    rst_n = 0; step(1);
    chk("e_wr_en", bus.wr_en, 0);
    chk("e_busy", bus.busy, 0);
    chk("e_rd_en", bus.mem_rd_en, 0);
    chk("e_addr", 32'(bus.mem_addr), 0);
    chk("e_wdata", 32'(bus.wr_data), 0);
    chk("e_cur", 32'(bus.cur_kernel), 0);
    aq.delete(); wq.delete();
    rst_n = 1; step(2);
    push_kernel(3, 10); kq.push_back(3); clr_cnt();
    pulse_start(0, 3);
    wait_done(100); step(2);
    chk("e_done_cnt", done_cnt, 1);
    chk("e_w11", 32'(sr[9]), 30);
    chk("e_bias", 32'(sr[0]), 39);

    // start while in CONV is dropped
    conv_lat = 8; push_kernel(1, 10); kq.push_back(1); clr_cnt();
    pulse_start(0, 1);
    n = 0;
    while (!bus.conv_start && n < 60) begin step(1); n++; end
    pulse_start(1, 0);
    wait_done(100); step(30);
    chk("f_done_cnt", done_cnt, 1);
    chk("f_cs_cnt", cs_cnt, 1);
    chk("f_busy", bus.busy, 0);

    chk("end_aq", aq.size(), 0);
    chk("end_wq", wq.size(), 0);
    chk("end_lq", lq.size(), 0);
    chk("end_kq", kq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
